// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Brief    : Iterative shifter controller. Captures one request per start
//            pulse and applies STEP bits of shift per cycle until the full
//            amount is consumed, then presents the result with a one-cycle
//            done strobe. Ops: 00 SLL, 01 SRL, 10 SRA, 11 pass-through.
//            Optional macro SHIFT_ROTATE_EN turns op 11 into rotate-right
//            by shamt[4:0].
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] in,
    input  logic [31:0] shamt,
    input  logic [1:0]  select,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic [5:0] c_step = 6'(STEP);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [31:0] r_data;
    logic [5:0]  r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_result;

    logic        w_accept;
    logic [5:0]  w_sat_amt;
    logic [5:0]  w_amt;
    logic        w_direct;
    logic [5:0]  w_k;
    logic        w_last;
    logic [31:0] w_shifted;

    // Request acceptance and capture-time amount decode
    always_comb begin
        w_accept  = start && ((r_state == c_st_idle) || (r_state == c_st_done));
        // Anything with a bit at or above position 5 is at least 32
        w_sat_amt = (|shamt[31:5]) ? 6'd32 : {1'b0, shamt[4:0]};
`ifdef SHIFT_ROTATE_EN
        // Rotate uses the raw low five bits; no saturation
        w_amt     = (select == 2'b11) ? {1'b0, shamt[4:0]} : w_sat_amt;
        w_direct  = (w_amt == 6'd0);
`else
        w_amt     = w_sat_amt;
        w_direct  = (w_amt == 6'd0) || (select == 2'b11);
`endif
    end

    // One iteration of the narrow shift datapath
    always_comb begin
        w_k    = (r_cnt < c_step) ? r_cnt : c_step;
        w_last = (r_cnt == w_k);
        case (r_op)
            2'b00:   w_shifted = r_data << w_k;
            2'b01:   w_shifted = r_data >> w_k;
            2'b10:   w_shifted = $signed(r_data) >>> w_k;
`ifdef SHIFT_ROTATE_EN
            // w_k is 1..31 here, so both partial shifts are well-defined
            default: w_shifted = (r_data >> w_k) | (r_data << (6'd32 - w_k));
`else
            default: w_shifted = r_data;
`endif
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and status decode
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_next_state = w_direct ? c_st_done : c_st_shift;
                end
            end
            c_st_shift: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = c_st_done;
                end
            end
            c_st_done: begin
                done = 1'b1;
                if (w_accept) begin
                    w_next_state = w_direct ? c_st_done : c_st_shift;
                end else begin
                    w_next_state = c_st_idle;
                end
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // Operand capture, iteration and result update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data   <= 32'd0;
            r_cnt    <= 6'd0;
            r_op     <= 2'd0;
            r_result <= 32'd0;
        end else if (w_accept) begin
            r_data <= in;
            r_cnt  <= w_amt;
            r_op   <= select;
            if (w_direct) begin
                r_result <= in;
            end
        end else if (r_state == c_st_shift) begin
            r_data <= w_shifted;
            r_cnt  <= r_cnt - w_k;
            if (w_last) begin
                r_result <= w_shifted;
            end
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer
// Brief    : Scoreboard bench for shift_sequencer. A driver issues directed
//            and random requests, predicting result, completion cycle and
//            SHIFT-cycle count from shift arithmetic; a monitor compares on
//            every done strobe and checks result stability in between.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    localparam int STEP = 4;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        int          nbusy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] din = 32'd0;
    logic [31:0] shamt = 32'd0;
    logic [1:0]  select = 2'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          cyc = 0;
    int          last_end = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          busy_cnt = 0;
    logic [31:0] last_res = 32'd0;
    exp_t        sb[$];

    shift_sequencer #(.STEP(STEP)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .in     (din),
        .shamt  (shamt),
        .select (select),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge number c, cyc == c
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat_amt(input logic [31:0] s);
        if (s >= 32) return 32;
        return int'(s[5:0]);
    endfunction

    function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] s,
                                            input logic [1:0] op);
        int amt;
        int r;
        amt = sat_amt(s);
        case (op)
            2'b00: return (amt == 32) ? 32'd0 : (a << amt);
            2'b01: return (amt == 32) ? 32'd0 : (a >> amt);
            2'b10: return (amt == 32) ? {32{a[31]}} : 32'($signed(a) >>> amt);
            default: begin
`ifdef SHIFT_ROTATE_EN
                r = int'(s[4:0]);
                if (r == 0) return a;
                return (a >> r) | (a << (32 - r));
`else
                r = 0;
                return a;
`endif
            end
        endcase
    endfunction

    function automatic int ref_n(input logic [31:0] s, input logic [1:0] op);
        int amt;
        if (op == 2'b11) begin
`ifdef SHIFT_ROTATE_EN
            amt = int'(s[4:0]);
`else
            amt = 0;
`endif
        end else begin
            amt = sat_amt(s);
        end
        return (amt + STEP - 1) / STEP;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one start pulse; the model decides whether the DUT can accept it
    task automatic req(input logic [31:0] a, input logic [31:0] s, input logic [1:0] op);
        int e;
        int n;
        e = cyc + 1;
        start = 1'b1;
        din = a;
        shamt = s;
        select = op;
        if (cyc >= last_end) begin
            n = ref_n(s, op);
            sb.push_back('{res: ref_res(a, s, op), cyc: e + n, nbusy: n});
            last_end = e + n;
        end
        step();
        start = 1'b0;
        din = $urandom;
        shamt = $urandom;
        select = 2'($urandom);
    endtask

    task automatic wait_ready();
        while (cyc < last_end) step();
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || cyc <= last_end) && t < 200) begin
            step();
            t++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: compare every done strobe against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cnt = 0;
            last_res = 32'd0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: result %h with nothing expected (cycle %0d)",
                             result, cyc);
                end else begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                    check("busy_cycles", 32'(busy_cnt), 32'(e.nbusy));
                end
                busy_cnt = 0;
                last_res = result;
            end else begin
                check("result_hold", result, last_res);
            end
        end
    end

    initial begin
        int r;
        int g;
        logic [31:0] s;

        // Reset state
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;
        last_end = cyc;
        step();

        // Directed cases
        req(32'h0000_0001, 32'd5, 2'b00);  drain();
        req(32'h8000_0000, 32'd40, 2'b10); drain();
        req(32'h8000_0000, 32'd40, 2'b01); drain();
        req(32'h8000_0000, 32'd31, 2'b01);
        step(); step();
        req(32'hDEAD_BEEF, 32'd3, 2'b00);  drain();
        req(32'h1234_5678, 32'd0, 2'b00);  drain();
        req(32'hCAFE_F00D, 32'd7, 2'b11);  drain();
        req(32'hF000_000F, 32'd32, 2'b10); drain();
        req(32'h7000_000F, 32'hFFFF_FFFF, 2'b10); drain();

        // Back-to-back: new start issued in the DONE cycle
        req(32'h0000_00FF, 32'd8, 2'b00);
        wait_ready();
        req(32'h0000_0003, 32'd4, 2'b00);
        wait_ready();
        req(32'hABCD_0123, 32'd0, 2'b01);
        wait_ready();
        req(32'h8765_4321, 32'd33, 2'b11);
        drain();

`ifdef SHIFT_ROTATE_EN
        req(32'h0000_0001, 32'd4, 2'b11);  drain();
        req(32'h8000_0001, 32'd35, 2'b11); drain();
`endif

        // Reset during SHIFT aborts with no done
        req(32'h8000_0000, 32'd20, 2'b10);
        step();
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'd0);
        sb.delete();
        step();
        rst = 1'b0;
        last_end = cyc;
        repeat (8) step();

        // Randomized traffic, including starts that land during SHIFT
        for (int i = 0; i < 300; i++) begin
            g = $urandom_range(0, 3);
            repeat (g) step();
            if ($urandom_range(0, 4) == 0) wait_ready();
            r = $urandom_range(0, 9);
            if (r < 6)      s = 32'($urandom_range(0, 40));
            else if (r < 8) s = 32'($urandom_range(28, 36));
            else            s = $urandom;
            req($urandom, s, 2'($urandom));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle iterative shifter controller for the KGP_RISC execute stage. It accepts one shift request per start pulse and captures the operand, amount and op. It then sequences a narrow STEP-bit-per-cycle shift datapath until the full amount is applied, and returns the result with a one-cycle done strobe. It lets the core trade a 32-bit barrel shifter for a smaller iterative one while keeping the same op encoding (00 SLL, 01 SRL, 10 SRA).

Parameters:
STEP, 4, bits shifted per SHIFT cycle; power of two, 1..32.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request strobe; sampled only when the block is in IDLE or DONE.
in  input  32  operand, treated as signed for SRA.
shamt  input  32  shift amount, unsigned.
select  input  2  op: 00 SLL, 01 SRL, 10 SRA, 11 pass-through (or ROR with option).
busy  output  1  high while in SHIFT.
done  output  1  one-cycle strobe; result valid.
result  output  32  final value, held until next completion.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. rst=1 forces state=IDLE, busy=0, done=0, result=0, internal data/count/op=0. Asserting rst mid-operation aborts the operation; no done is produced.
- States:
  - IDLE: wait for start.
  - SHIFT: iterate.
  - DONE: done=1 for exactly one cycle.
- Acceptance:
  - start=1 at a rising edge in IDLE or DONE captures in, select and A = min(shamt,32) as a 6-bit saturated count.
  - Any shamt >= 32 is treated as 32.
  - start in SHIFT is ignored; the operand is not queued.
- Transitions on acceptance at edge T:
  - If A==0 or select==11 (no option), next state is DONE. done=1 in cycle T+1 and result=in.
  - Otherwise the next state is SHIFT.
- SHIFT operation, each cycle:
  - k = min(STEP, remaining).
  - data <= data shifted by k per op. SLL and SRL zero-fill; SRA replicates the captured bit 31.
  - remaining <= remaining - k.
  - When remaining-k == 0, next state is DONE and result <= final data.
- Latency: N = ceil(A/STEP) SHIFT cycles. done is high in cycle T+1+N. busy is high in cycles T+1..T+N.
- DONE state:
  - If start=1, a new request is accepted (back-to-back); otherwise the next state is IDLE.
  - done is never high two consecutive cycles unless the second request has A==0 or is a pass-through.
- Amount 32 results: SLL and SRL give 0x00000000; SRA gives 0x00000000 or 0xFFFFFFFF per the sign.
- result changes only on the edge entering DONE; it is stable otherwise.
- Inputs are not required to be stable after the accepting edge.

Optional Feature:
SHIFT_ROTATE_EN:
- Defined: select=11 performs a rotate right by shamt[4:0]; the count is not saturated.
  - Each SHIFT cycle rotates by k.
  - N = ceil(shamt[4:0]/STEP).
  - shamt[4:0]==0 goes directly to DONE with result=in.
- Undefined: select=11 is a pass-through. It completes in 1 cycle with result=in, and no SHIFT cycles occur.

Test Plan:
- STEP=4, SLL, in=0x00000001, shamt=5, start at T: busy at T+1..T+2, done at T+3, result=0x00000020.
- SRA, in=0x80000000, shamt=40: A saturates to 32, 8 SHIFT cycles, done at T+9, result=0xFFFFFFFF. Repeat with SRL: result=0x00000000.
- SRL, in=0x80000000, shamt=31: 8 SHIFT cycles, result=0x00000001. Pulse start again during SHIFT with different operands: ignored, result unchanged.
- shamt=0, SLL, in=0x12345678: done at T+1, result=0x12345678, busy never high.
- Back-to-back: assert start in the DONE cycle with SLL in=0x3, shamt=4. The new request is accepted, 1 SHIFT cycle follows, result=0x00000030.
- Assert rst during SHIFT of an SRA by 20: busy, done and result go to 0 immediately; no done follows. With SHIFT_ROTATE_EN, select=11, in=0x00000001, shamt=4: result=0x10000000.
